// File: rtl/ps2_rx_hexdisp.sv
// PS/2 keyboard receiver on the system clock, with scan-code history on a multiplexed hex display.
// Optional macro PS2_BREAK_FILTER_EN keeps break sequences (F0 xx) out of the history.
module ps2_rx_hexdisp #(
  parameter int NUM_BYTES   = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2c,
  input  logic                   ps2d,
  output logic                   data_valid,
  output logic [7:0]             data_out,
  output logic                   frame_err,
  output logic [8*NUM_BYTES-1:0] history,
  output logic [6:0]             seg,
  output logic [2*NUM_BYTES-1:0] an
);

  localparam int HIST_W = 8*NUM_BYTES;
  localparam int DIGITS = 2*NUM_BYTES;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]       FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic       ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
  logic       c_flt_p2, d_flt_p2, c_flt_prev;
  logic [7:0] c_cnt, d_cnt;
  logic       sample;

  // p0/p1: two-FF synchronisers; p2: stability filters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_p0    <= 1'b1;
      ps2c_p1    <= 1'b1;
      ps2d_p0    <= 1'b1;
      ps2d_p1    <= 1'b1;
      c_flt_p2   <= 1'b1;
      d_flt_p2   <= 1'b1;
      c_flt_prev <= 1'b1;
      c_cnt      <= '0;
      d_cnt      <= '0;
    end else begin
      ps2c_p0    <= ps2c;
      ps2c_p1    <= ps2c_p0;
      ps2d_p0    <= ps2d;
      ps2d_p1    <= ps2d_p0;
      c_flt_prev <= c_flt_p2;
      if (ps2c_p1 != c_flt_p2) begin
        if (c_cnt == FLT_LAST) begin
          c_flt_p2 <= ps2c_p1;
          c_cnt    <= '0;
        end else begin
          c_cnt <= c_cnt + 8'd1;
        end
      end else begin
        c_cnt <= '0;
      end
      if (ps2d_p1 != d_flt_p2) begin
        if (d_cnt == FLT_LAST) begin
          d_flt_p2 <= ps2d_p1;
          d_cnt    <= '0;
        end else begin
          d_cnt <= d_cnt + 8'd1;
        end
      end else begin
        d_cnt <= '0;
      end
    end
  end

  assign sample = c_flt_prev & ~c_flt_p2;

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             good_d, err_d;

  // Deframer state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    good_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (sample && !d_flt_p2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d   = {d_flt_p2, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
          par_d   = d_flt_p2;
          state_d = STOP;
        end
      end
      default: begin
        if (sample) begin
          state_d = IDLE;
          if (d_flt_p2 && (^{shreg_q, par_q})) good_d = 1'b1;
          else                                  err_d  = 1'b1;
        end
      end
    endcase
    // Watchdog between falling edges; a sample event always wins
    if (state_q != IDLE) begin
      if (sample) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic brk_q;
`endif

  // Result stage: pulses, byte and history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      data_out   <= '0;
      history    <= '0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      data_valid <= good_d;
      frame_err  <= err_d;
      if (good_d) data_out <= shreg_q;
`ifdef PS2_BREAK_FILTER_EN
      if (err_d) begin
        brk_q <= 1'b0;
      end else if (good_d) begin
        if (brk_q)                  brk_q   <= 1'b0;
        else if (shreg_q == 8'hF0)  brk_q   <= 1'b1;
        else                        history <= HIST_W'({history, shreg_q});
      end
`else
      if (good_d) history <= HIST_W'({history, shreg_q});
`endif
    end
  end

  logic [REF_W-1:0] ref_q;
  logic [DIG_W-1:0] dig_q;
  logic [3:0]       nib;

  assign nib = 4'(history >> {dig_q, 2'b00});

  // Display stage: seg and an registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q <= '0;
      dig_q <= '0;
      seg   <= 7'b1111111;
      an    <= '1;
    end else begin
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        dig_q <= (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
      end else begin
        ref_q <= ref_q + REF_W'(1);
      end
      seg <= hex7(nib);
      an  <= ~(DIGITS'(1) << dig_q);
    end
  end

endmodule

// File: tb/tb_ps2_rx_hexdisp.sv
// Randomised bench for ps2_rx_hexdisp: PS/2 frame driver, queue-based history model, display sweep.
module tb_ps2_rx_hexdisp;
  localparam int NB   = 2;
  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int RD   = 20;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset, ps2c, ps2d;
  logic data_valid, frame_err;
  logic [7:0] data_out;
  logic [8*NB-1:0] history;
  logic [6:0] seg;
  logic [2*NB-1:0] an;

  always #5 clk = ~clk;

  ps2_rx_hexdisp #(.NUM_BYTES(NB), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .data_valid(data_valid), .data_out(data_out), .frame_err(frame_err),
    .history(history), .seg(seg), .an(an)
  );

  int checks = 0, failures = 0;
  int cyc = 0, stop_fall_cyc = 0;
  int vld_cnt = 0, err_cnt = 0;
  logic prev_vld = 1'b0, prev_err = 1'b0;

  logic [7:0] hist_q[$];
  logic [7:0] exp_data;
  int exp_vld = 0, exp_err = 0;
  bit brk = 0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        vld_cnt <= vld_cnt + 1;
        check_eq("vld_one_cycle", 32'(prev_vld), 0);
        check_eq("vld_err_excl", 32'(frame_err), 0);
        check_eq("vld_latency", 32'((cyc - stop_fall_cyc) <= FL + 4), 1);
      end
      if (frame_err) begin
        err_cnt <= err_cnt + 1;
        check_eq("err_one_cycle", 32'(prev_err), 0);
      end
    end
    prev_vld <= data_valid;
    prev_err <= frame_err;
  end

  function automatic logic [8*NB-1:0] hist_val();
    logic [8*NB-1:0] v = '0;
    for (int k = 0; k < hist_q.size(); k++) v |= (8*NB)'(hist_q[k]) << (8*k);
    return v;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    repeat (NB) hist_q.push_back(8'h00);
    exp_data = 8'h00;
    brk = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    hist_q.push_front(b);
    void'(hist_q.pop_back());
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_vld++;
    exp_data = b;
`ifdef PS2_BREAK_FILTER_EN
    if (brk)            brk = 0;
    else if (b == 8'hF0) brk = 1;
    else                 model_push(b);
`else
    model_push(b);
`endif
  endtask

  task automatic model_err();
    exp_err++;
    brk = 0;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = fr[i];
      repeat (HALF - 1) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_vld_count"}, vld_cnt, exp_vld);
    check_eq({tag, "_err_count"}, err_cnt, exp_err);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'(exp_data));
    check_eq({tag, "_history"}, 32'(history), 32'(hist_val()));
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
    if (bad_par || bad_stop) model_err();
    else                     model_good(b);
    check_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(data_valid), 0);
    check_eq({tag, "_err"}, 32'(frame_err), 0);
    check_eq({tag, "_data"}, 32'(data_out), 0);
    check_eq({tag, "_hist"}, 32'(history), 0);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
  endtask

  task automatic display_sweep();
    int last = -1;
    logic [2*NB-1:0] seen = '0;
    logic [8*NB-1:0] hv;
    logic [3:0] nib;
    int z, idx;
    hv = hist_val();
    repeat (2*NB*RD + 2) begin
      @(negedge clk);
      z = 0;
      idx = 0;
      for (int i = 0; i < 2*NB; i++) if (!an[i]) begin z++; idx = i; end
      check_eq("an_onehot", z, 1);
      nib = 4'(hv >> (4*idx));
      check_eq("seg_digit", 32'(seg), 32'(hex_tab[nib]));
      if (idx != last) begin
        if (last >= 0) check_eq("digit_order", idx, (last + 1) % (2*NB));
        last = idx;
        seen[idx] = 1'b1;
      end
    end
    check_eq("all_digits_seen", 32'(seen), 32'hF);
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);

    send_byte("b1c", 8'h1C, 0, 0);
    send_byte("b32", 8'h32, 0, 0);
    check_eq("hist_1c32", 32'(history), 32'h1C32);
    display_sweep();

    send_byte("badpar", 8'h1C, 1, 0);

    send_bits(mk_frame(8'h5A, 0, 0), 5);
    ps2d = 1'b1;
    repeat (TO + FL + 20) @(negedge clk);
    model_err();
    check_state("timeout");
    send_byte("b2a", 8'h2A, 0, 0);

    send_bits(mk_frame(8'h77, 0, 0), 6);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    ps2d = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    send_byte("b45", 8'h45, 0, 0);

    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (30) @(negedge clk);
    check_state("glitch");
    send_byte("b33", 8'h33, 0, 0);

    send_byte("brk_a", 8'h1C, 0, 0);
    send_byte("brk_f0", 8'hF0, 0, 0);
    send_byte("brk_b", 8'h1C, 0, 0);

    for (int n = 0; n < 14; n++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 50)) @(negedge clk);
      send_byte("rnd", b, kind == 8, kind == 9);
    end
    display_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
